// File: rtl/otter_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// otter_mem_port_arbiter
//
// Shares one variable-latency memory port between the OTTER pipeline's
// instruction-fetch requester (IF) and its MEM-stage data requester (D).
// Only one access is in flight at a time. A watchdog aborts an access the
// memory never acknowledges. An aborted access returns ERR_DATA and sets a
// sticky error flag. Every output is driven straight from a flop.
//
// State sequence: IDLE -> BUSY -> RESP -> (BUSY | IDLE)
//
// Build option:
//   OTTER_ARB_RR_EN  undefined : fixed priority. D wins a tie over IF.
//   OTTER_ARB_RR_EN  defined   : round-robin. A tie goes to the requester
//                                that was not served last.
//
// Parameters:
//   ADDR_W    address width of all address ports
//   DATA_W    data width of all data ports
//   TIMEOUT   maximum BUSY cycles without m_ack_i before an abort
//             (0 disables the watchdog)
//   ERR_DATA  read data returned by an aborted access
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   if_req_i     fetch request, held with if_addr_i until if_ack_o
//   if_addr_i    fetch address
//   if_rdata_o   fetched word, valid while if_ack_o=1
//   if_ack_o     one-cycle completion pulse to IF
//   d_req_i      data request, held with d_* until d_ack_o
//   d_we_i       1 = store, 0 = load
//   d_addr_i     data address
//   d_wdata_i    store data
//   d_size_i     00 byte, 01 half, 10 word
//   d_rdata_o    load data, valid while d_ack_o=1
//   d_ack_o      one-cycle completion pulse to D
//   m_req_o      memory request, held until m_ack_i or abort
//   m_we_o       memory write enable
//   m_addr_o     memory address
//   m_wdata_o    memory write data
//   m_size_o     memory access size (always 10 for IF)
//   m_rdata_i    memory read data, sampled when m_ack_i=1
//   m_ack_i      memory completion; may arrive in the first m_req_o cycle
//   busy_o       high whenever the arbiter is not idle
//   err_o        sticky watchdog-abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module otter_mem_port_arbiter #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 TIMEOUT  = 15,
    parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [1:0]        d_size_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              m_req_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic [1:0]        m_size_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic              m_ack_i,
    output logic              busy_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // The timer only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e             state_q;
    logic               owner_d_q;     // 1: the access in flight belongs to D
    logic [TW-1:0]      timer_q;
    logic               m_req_q;
    logic               m_we_q;
    logic [ADDR_W-1:0]  m_addr_q;
    logic [DATA_W-1:0]  m_wdata_q;
    logic [1:0]         m_size_q;
    logic [DATA_W-1:0]  if_rdata_q;
    logic               if_ack_q;
    logic [DATA_W-1:0]  d_rdata_q;
    logic               d_ack_q;
    logic               busy_q;
    logic               err_q;
`ifdef OTTER_ARB_RR_EN
    logic               rr_ptr_d_q;    // 1: D is preferred on the next tie
`endif

    logic               tie_pick_d_s;
    logic               grant_s;
    logic               grant_d_s;
    logic               sel_we_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic [1:0]         sel_size_s;
    logic               timeout_s;
    logic [DATA_W-1:0]  resp_data_s;

    // Winner of a simultaneous request from IDLE.
    always_comb begin
`ifdef OTTER_ARB_RR_EN
        tie_pick_d_s = rr_ptr_d_q;
`else
        tie_pick_d_s = 1'b1;
`endif
    end

    // Grant decision. In RESP only the requester that was not just served
    // can win, so the pipeline gets a back-to-back handover without an IDLE bubble.
    always_comb begin
        grant_s   = 1'b0;
        grant_d_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_req_i && if_req_i) begin
                    grant_s   = 1'b1;
                    grant_d_s = tie_pick_d_s;
                end else if (d_req_i) begin
                    grant_s   = 1'b1;
                    grant_d_s = 1'b1;
                end else if (if_req_i) begin
                    grant_s   = 1'b1;
                    grant_d_s = 1'b0;
                end else begin
                    grant_s   = 1'b0;
                    grant_d_s = 1'b0;
                end
            end
            ST_RESP: begin
                if (owner_d_q) begin
                    grant_s   = if_req_i;
                    grant_d_s = 1'b0;
                end else begin
                    grant_s   = d_req_i;
                    grant_d_s = 1'b1;
                end
            end
            default: begin
                grant_s   = 1'b0;
                grant_d_s = 1'b0;
            end
        endcase
    end

    // Memory-side fields of the granted requester. A fetch is always a word read.
    always_comb begin
        if (grant_d_s) begin
            sel_we_s    = d_we_i;
            sel_addr_s  = d_addr_i;
            sel_wdata_s = d_wdata_i;
            sel_size_s  = d_size_i;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = if_addr_i;
            sel_wdata_s = {DATA_W{1'b0}};
            sel_size_s  = 2'b10;
        end
    end

    // The watchdog fires in the last allowed BUSY cycle. An m_ack_i in that
    // same cycle still wins.
    assign timeout_s   = (TIMEOUT != 0) && (timer_q == TIMER_LAST);
    assign resp_data_s = m_ack_i ? m_rdata_i : ERR_DATA;

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            owner_d_q  <= 1'b0;
            timer_q    <= {TW{1'b0}};
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= {ADDR_W{1'b0}};
            m_wdata_q  <= {DATA_W{1'b0}};
            m_size_q   <= 2'b00;
            if_rdata_q <= {DATA_W{1'b0}};
            if_ack_q   <= 1'b0;
            d_rdata_q  <= {DATA_W{1'b0}};
            d_ack_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef OTTER_ARB_RR_EN
            rr_ptr_d_q <= 1'b1;
`endif
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_q   <= ST_BUSY;
                        busy_q    <= 1'b1;
                        owner_d_q <= grant_d_s;
                        timer_q   <= {TW{1'b0}};
                        m_req_q   <= 1'b1;
                        m_we_q    <= sel_we_s;
                        m_addr_q  <= sel_addr_s;
                        m_wdata_q <= sel_wdata_s;
                        m_size_q  <= sel_size_s;
                    end
                end
                ST_BUSY: begin
                    timer_q <= timer_q + TW'(1);
                    if (m_ack_i || timeout_s) begin
                        state_q <= ST_RESP;
                        m_req_q <= 1'b0;
                        if (owner_d_q) begin
                            d_rdata_q <= resp_data_s;
                            d_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= resp_data_s;
                            if_ack_q   <= 1'b1;
                        end
                        if (!m_ack_i) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
`ifdef OTTER_ARB_RR_EN
                    rr_ptr_d_q <= ~owner_d_q;
`endif
                    if (grant_s) begin
                        state_q   <= ST_BUSY;
                        owner_d_q <= grant_d_s;
                        timer_q   <= {TW{1'b0}};
                        m_req_q   <= 1'b1;
                        m_we_q    <= sel_we_s;
                        m_addr_q  <= sel_addr_s;
                        m_wdata_q <= sel_wdata_s;
                        m_size_q  <= sel_size_s;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o = if_rdata_q;
    assign if_ack_o   = if_ack_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_ack_o    = d_ack_q;
    assign m_req_o    = m_req_q;
    assign m_we_o     = m_we_q;
    assign m_addr_o   = m_addr_q;
    assign m_wdata_o  = m_wdata_q;
    assign m_size_o   = m_size_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_otter_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for otter_mem_port_arbiter.
// Part 1 uses a table of single-access vectors, replayed in a loop.
// Part 2 uses hand-written sequences for arbitration and mid-access reset.
// Part 3 uses random traffic checked against a transaction-level model.
// The model predicts the grant from the pending requests, the ACK cycle as
// min(delay+1, TIMEOUT), the returned data and the sticky error.
// ---------------------------------------------------------------------------
module tb_otter_mem_port_arbiter;

    localparam int TO = 15;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we, m_ack;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_size;
    logic [31:0] if_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
    logic        if_ack_o, d_ack_o, m_req_o, m_we_o, busy_o, err_o;
    logic [1:0]  m_size_o;

    int checks = 0;
    int errors = 0;

    otter_mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_size_i(d_size),
        .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
        .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_size_o(m_size_o), .m_rdata_i(m_rdata), .m_ack_i(m_ack),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'b00; m_ack = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        int          delay;      // BUSY cycles before m_ack; >= TO means never
        logic [31:0] mem_data;
        logic [1:0]  exp_size;
        int          exp_lat;    // cycles from first m_req sample to ACK sample
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    // One isolated access starting from IDLE.
    task automatic do_xfer(input vec_t v);
        logic got;
        logic ackv;
        int   lat;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_size = v.size;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        m_ack = 1'b0;
        step();
        chk("grant_m_req", {31'h0, m_req_o}, 32'h1);
        chk("grant_m_addr", m_addr_o, v.addr);
        chk("grant_m_we", {31'h0, m_we_o}, {31'h0, v.is_d & v.we});
        chk("grant_m_size", {30'h0, m_size_o}, {30'h0, v.exp_size});
        if (v.is_d && v.we) chk("grant_m_wdata", m_wdata_o, v.wdata);
        chk("grant_busy", {31'h0, busy_o}, 32'h1);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            m_ack   = (k == v.delay);
            m_rdata = (k == v.delay) ? v.mem_data : ~v.mem_data;
            step();
            lat++;
            ackv = v.is_d ? d_ack_o : if_ack_o;
            if (ackv) begin
                got = 1'b1;
            end else begin
                chk("hold_m_fields", {m_req_o, m_addr_o[30:0]}, {1'b1, v.addr[30:0]});
            end
        end
        chk("ack_seen", {31'h0, got}, 32'h1);
        chk("ack_latency", lat, v.exp_lat);
        chk("ack_rdata", v.is_d ? d_rdata_o : if_rdata_o, v.exp_rdata);
        chk("other_ack_low", {31'h0, v.is_d ? if_ack_o : d_ack_o}, 32'h0);
        chk("m_req_dropped", {31'h0, m_req_o}, 32'h0);
        chk("err_flag", {31'h0, err_o}, {31'h0, v.exp_err});
        if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
        step();
        chk("ack_one_cycle", {30'h0, d_ack_o, if_ack_o}, 32'h0);
        chk("back_to_idle", {31'h0, busy_o}, 32'h0);
    endtask

    // Transaction-level reference model state.
    typedef struct {
        logic        pend;
        logic        lvl;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } rq_t;

    rq_t         rq[2];          // index 0 = IF, 1 = D
    logic        inflight, pend_grant, err_m;
    int          owner, k_m, delay_m, exp_k, last_served, acked;
    logic [31:0] exp_data;

    task automatic rnd_new_req(input int r);
        rq[r].pend  = 1'b1;
        rq[r].lvl   = 1'b1;
        rq[r].addr  = {(r == 1) ? 4'hD : 4'h1, 28'($urandom)};
        rq[r].we    = (r == 1) ? 1'($urandom_range(1)) : 1'b0;
        rq[r].wdata = $urandom;
        rq[r].size  = (r == 1) ? 2'($urandom_range(2)) : 2'b10;
    endtask

    task automatic run_random(input int n);
        logic cand_if, cand_d, tie_d;
        for (int r = 0; r < 2; r++) begin
            rq[r].pend = 1'b0; rq[r].lvl = 1'b0; rq[r].we = 1'b0;
            rq[r].addr = 32'h0; rq[r].wdata = 32'h0; rq[r].size = 2'b00;
        end
        inflight = 1'b0; pend_grant = 1'b0; err_m = 1'b0; owner = 0;
        k_m = 0; delay_m = 0; exp_k = 0; exp_data = 32'h0;
        last_served = 0;   // after reset D is preferred on a tie
        for (int it = 0; it < n; it++) begin
            acked = -1;
            if (pend_grant) begin
                pend_grant = 1'b0;
                inflight   = 1'b1;
                k_m        = 0;
                chk("rnd_grant", {m_req_o, d_ack_o, if_ack_o, m_we_o}, {1'b1, 2'b00, rq[owner].we});
                chk("rnd_grant_addr", m_addr_o, rq[owner].addr);
                chk("rnd_grant_size", {30'h0, m_size_o}, {30'h0, rq[owner].size});
                if (owner == 1 && rq[1].we) chk("rnd_grant_wdata", m_wdata_o, rq[1].wdata);
            end else if (inflight) begin
                k_m++;
                if (k_m == exp_k) begin
                    chk("rnd_ack", {29'h0, m_req_o, d_ack_o, if_ack_o}, (owner == 1) ? 32'h2 : 32'h1);
                    chk("rnd_rdata", (owner == 1) ? d_rdata_o : if_rdata_o, exp_data);
                    if (delay_m >= TO) err_m = 1'b1;
                    inflight = 1'b0;
                    acked = owner;
                    last_served = owner;
                    rq[owner].pend = 1'b0;
                end else begin
                    chk("rnd_busy_hold", {29'h0, m_req_o, d_ack_o, if_ack_o}, 32'h4);
                end
            end else begin
                chk("rnd_idle_quiet", {29'h0, m_req_o, d_ack_o, if_ack_o}, 32'h0);
            end
            chk("rnd_err", {31'h0, err_o}, {31'h0, err_m});
            chk("rnd_busy", {31'h0, busy_o}, {31'h0, inflight || (acked >= 0)});

            // Requester agents: hold until ACK; the owner may drop REQ mid-access.
            for (int r = 0; r < 2; r++) begin
                if (rq[r].pend) begin
                    if (inflight && owner == r && $urandom_range(7) == 0) rq[r].lvl = 1'b0;
                end else if ($urandom_range(2) == 0 || (acked == r && $urandom_range(1) == 0)) begin
                    rnd_new_req(r);
                end else begin
                    rq[r].lvl = 1'b0;
                end
            end
            if_req = rq[0].lvl; if_addr = rq[0].addr;
            d_req = rq[1].lvl; d_we = rq[1].we; d_addr = rq[1].addr;
            d_wdata = rq[1].wdata; d_size = rq[1].size;

            // Next grant. The requester just acknowledged is not eligible this cycle.
            if (!inflight) begin
                cand_if = rq[0].lvl && (acked != 0);
                cand_d  = rq[1].lvl && (acked != 1);
`ifdef OTTER_ARB_RR_EN
                tie_d = (last_served != 1);
`else
                tie_d = 1'b1;
`endif
                if (cand_if || cand_d) begin
                    pend_grant = 1'b1;
                    owner   = (cand_if && cand_d) ? (tie_d ? 1 : 0) : (cand_d ? 1 : 0);
                    delay_m = ($urandom_range(9) == 0) ? 13 + $urandom_range(6) : $urandom_range(4);
                    exp_k   = (delay_m + 1 < TO) ? delay_m + 1 : TO;
                    exp_data = (delay_m >= TO) ? ERRD : $urandom;
                end
            end

            // Memory: ACK after delay_m BUSY cycles, random ACK noise while idle.
            if (inflight) begin
                m_ack   = (k_m == delay_m);
                m_rdata = (k_m == delay_m) ? exp_data : $urandom;
            end else begin
                m_ack   = 1'($urandom_range(1));
                m_rdata = $urandom;
            end
            step();
        end
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        logic [31:0] exp_addr;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 2'b00, 0,  32'h0000_0013, 2'b10, 1,  32'h0000_0013, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 2'b01, 4, 32'h0BAD_0BAD, 2'b01, 5, 32'h0BAD_0BAD, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0, 2'b00, 14, 32'h0000_00A5, 2'b00, 15, 32'h0000_00A5, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 2'b00, 99, 32'h1111_2222, 2'b10, 15, ERRD, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 2'b10, 2,  32'h1234_5678, 2'b10, 3,  32'h1234_5678, 1'b1};

        do_reset();
        chk("reset_outputs", {26'h0, m_req_o, busy_o, err_o, if_ack_o, d_ack_o, m_we_o}, 32'h0);
        chk("reset_m_addr", m_addr_o, 32'h0);
        chk("reset_rdata", if_rdata_o | d_rdata_o, 32'h0);

        for (int i = 0; i < 5; i++) do_xfer(vecs[i]);

        // Tie from IDLE: D first, IF handed the port in D's RESP cycle.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0D00; d_size = 2'b10;
        step();
        chk("tie_d_first", m_addr_o, 32'h0000_0D00);
        m_ack = 1'b1; m_rdata = 32'hAAAA_0001;
        step();
        chk("tie_d_ack", {30'h0, d_ack_o, if_ack_o}, 32'h2);
        chk("tie_d_rdata", d_rdata_o, 32'hAAAA_0001);
        d_req = 1'b0; m_ack = 1'b0;
        step();
        chk("b2b_if_grant", {m_req_o, busy_o, m_addr_o[29:0]}, {2'b11, 30'h0000_0400});
        m_ack = 1'b1; m_rdata = 32'hBBBB_0002;
        step();
        chk("b2b_if_ack", {30'h0, d_ack_o, if_ack_o}, 32'h1);
        chk("b2b_if_rdata", if_rdata_o, 32'hBBBB_0002);
        if_req = 1'b0; m_ack = 1'b0;
        step();
        chk("b2b_idle", {31'h0, busy_o}, 32'h0);

        // Tie winners across separate IDLE rounds.
        for (int r = 0; r < 4; r++) begin
`ifdef OTTER_ARB_RR_EN
            exp_addr = (r % 2 == 0) ? 32'h0000_0D00 : 32'h0000_0400;
`else
            exp_addr = 32'h0000_0D00;
`endif
            if_req = 1'b1; d_req = 1'b1; m_ack = 1'b0;
            step();
            chk("idle_tie_winner", m_addr_o, exp_addr);
            m_ack = 1'b1;
            step();
            if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
            step();
        end

`ifdef OTTER_ARB_RR_EN
        // Both requests held continuously: grants alternate D, IF, D, IF.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_req = 1'b1; d_addr = 32'h0000_0D00; d_size = 2'b10;
        for (int g = 0; g < 4; g++) begin
            m_ack = 1'b0;
            step();
            chk("rr_alternate", m_addr_o, (g % 2 == 0) ? 32'h0000_0D00 : 32'h0000_0400);
            m_ack = 1'b1;
            step();
        end
        clear_inputs();
        step();
        step();
`endif

        // Reset in the middle of an access.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0200;
        step();
        chk("pre_reset_busy", {31'h0, m_req_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {26'h0, m_req_o, busy_o, err_o, if_ack_o, d_ack_o, m_we_o}, 32'h0);
        chk("async_reset_addr", {m_addr_o[31:2], m_size_o}, 32'h0);
        if_req = 1'b0; m_ack = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("no_ack_after_reset", {29'h0, busy_o, d_ack_o, if_ack_o}, 32'h0);
        end
        m_ack = 1'b0;
        do_xfer('{1'b0, 1'b0, 32'h0000_0208, 32'h0, 2'b00, 1, 32'h0000_0093, 2'b10, 2, 32'h0000_0093, 1'b0});

        do_reset();
        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
